// File: rtl/seq_pkg.sv
// seq_pkg: shared opcode, source-select and FSM types for the
// microprogram next-address controller.
package seq_pkg;

  typedef enum logic [3:0] {
    OP_JZ   = 4'd0,
    OP_CJS  = 4'd1,
    OP_JMAP = 4'd2,
    OP_CJP  = 4'd3,
    OP_PUSH = 4'd4,
    OP_JSRP = 4'd5,
    OP_CJV  = 4'd6,
    OP_JRP  = 4'd7,
    OP_RFCT = 4'd8,
    OP_RPCT = 4'd9,
    OP_CRTN = 4'd10,
    OP_CJPP = 4'd11,
    OP_LDCT = 4'd12,
    OP_LOOP = 4'd13,
    OP_CONT = 4'd14,
    OP_TWB  = 4'd15
  } opcode_t;

  localparam logic [1:0] SRC_PC  = 2'b00;
  localparam logic [1:0] SRC_AR  = 2'b01;
  localparam logic [1:0] SRC_STK = 2'b10;
  localparam logic [1:0] SRC_D   = 2'b11;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/seq_loop_counter.sv
// seq_loop_counter: loop counter with parallel load and
// decrement, reporting when it holds zero.
module seq_loop_counter #(
  parameter int CW = 12
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          load,
  input  logic          dec,
  input  logic [CW-1:0] d,
  output logic          cnt_zero
);

  logic [CW-1:0] cnt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= d;
    end else if (dec) begin
      cnt <= cnt - CW'(1);
    end
  end

  assign cnt_zero = (cnt == '0);

endmodule

// File: rtl/seq_control.sv
// seq_control: Am2910-style next-address decoder driving 4-bit
// sequencer slices. Define SEQ_STACK_GUARD_EN to block pushes at full.
module seq_control
  import seq_pkg::*;
#(
  parameter int CW          = 12,
  parameter int STACK_DEPTH = 4
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [3:0]    instr,
  input  logic          ccen_n,
  input  logic          cc_n,
  input  logic [CW-1:0] d,
  output logic          s1,
  output logic          s0,
  output logic          zero_n,
  output logic          fe_n,
  output logic          pup,
  output logic          re_n,
  output logic          cin,
  output logic          pl_n,
  output logic          map_n,
  output logic          vect_n,
  output logic          cnt_zero,
  output logic          full,
  output logic          underflow,
  output logic          overflow
);

  localparam int DW = $clog2(STACK_DEPTH + 1);

  state_t        state;
  opcode_t       op;
  logic          pass;
  logic [1:0]    src;
  logic          push;
  logic          pop;
  logic          load;
  logic          dec;
  logic          clr;
  logic          push_blk;
  logic [DW-1:0] depth;

  assign op   = opcode_t'(instr);
  assign pass = ccen_n | ~cc_n;
  assign full = (depth == DW'(STACK_DEPTH));

  always_comb begin
    src    = SRC_PC;
    zero_n = 1'b1;
    push   = 1'b0;
    pop    = 1'b0;
    load   = 1'b0;
    dec    = 1'b0;
    clr    = 1'b0;
    pl_n   = 1'b0;
    map_n  = 1'b1;
    vect_n = 1'b1;
    cin    = 1'b1;
    if (state == ST_INIT) begin
      zero_n = 1'b0;
    end else begin
      unique case (op)
        OP_JZ: begin
          zero_n = 1'b0;
          clr    = 1'b1;
        end
        OP_CJS: if (pass) begin
          src  = SRC_D;
          push = 1'b1;
        end
        OP_JMAP: begin
          src   = SRC_D;
          map_n = 1'b0;
          pl_n  = 1'b1;
        end
        OP_CJP: if (pass) src = SRC_D;
        OP_PUSH: begin
          push = 1'b1;
          load = pass;
        end
        OP_JSRP: begin
          src  = pass ? SRC_D : SRC_AR;
          push = 1'b1;
        end
        OP_CJV: if (pass) begin
          src    = SRC_D;
          vect_n = 1'b0;
          pl_n   = 1'b1;
        end
        OP_JRP: src = pass ? SRC_D : SRC_AR;
        OP_RFCT: if (!cnt_zero) begin
          src = SRC_STK;
          dec = 1'b1;
        end else begin
          pop = 1'b1;
        end
        OP_RPCT: if (!cnt_zero) begin
          src = SRC_D;
          dec = 1'b1;
        end
        OP_CRTN: if (pass) begin
          src = SRC_STK;
          pop = 1'b1;
        end
        OP_CJPP: if (pass) begin
          src = SRC_D;
          pop = 1'b1;
        end
        OP_LDCT: load = 1'b1;
        OP_LOOP: if (pass) pop = 1'b1;
                 else src = SRC_STK;
        OP_CONT: src = SRC_PC;
        OP_TWB: if (pass) begin
          pop = 1'b1;
        end else if (!cnt_zero) begin
          src = SRC_STK;
          dec = 1'b1;
        end else begin
          src = SRC_D;
          pop = 1'b1;
        end
      endcase
    end
  end

`ifdef SEQ_STACK_GUARD_EN
  assign push_blk = push & full;
`else
  assign push_blk = 1'b0;
`endif

  assign s1   = src[1];
  assign s0   = src[0];
  assign fe_n = ~((push & ~push_blk) | pop);
  assign pup  = push;
  assign re_n = ~load;

  // Counter and slice AR load together so AR mirrors the count.
  seq_loop_counter #(.CW(CW)) u_cnt (
    .clock    (clock),
    .reset    (reset),
    .load     (load),
    .dec      (dec),
    .d        (d),
    .cnt_zero (cnt_zero)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= ST_INIT;
      depth     <= '0;
      underflow <= 1'b0;
      overflow  <= 1'b0;
    end else if (state == ST_INIT) begin
      state <= ST_RUN;
    end else begin
      if (clr) begin
        depth <= '0;
      end else if (push) begin
        if (!full) depth <= depth + DW'(1);
`ifdef SEQ_STACK_GUARD_EN
        if (push_blk) overflow <= 1'b1;
`endif
      end else if (pop) begin
        if (depth == '0) underflow <= 1'b1;
        else depth <= depth - DW'(1);
      end
    end
  end

endmodule
